// File: rtl/mmio_arbiter_pkg.sv
// rtl/mmio_arbiter_pkg.sv - shared state encoding, default map and peripheral select for the MMIO arbiter
package mmio_arbiter_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Default MMIO map: base compared on [31:8], offsets compared on [7:2]
   localparam logic [31:0] DEF_IO_BASE = 32'hFFFF_FC00;
   localparam logic [7:0]  DEF_LED_OFS = 8'h60;
   localparam logic [7:0]  DEF_SW_OFS  = 8'h70;
   localparam logic [7:0]  DEF_SEG_OFS = 8'h80;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_LED  = 2'd1,
      SEL_SW   = 2'd2,
      SEL_SEG  = 2'd3
   } periph_sel_e;

   // Word-granular offset match; the low two address bits are the peripheral sub-address
   function automatic logic ofs_match(input logic [7:2] addr_lo, input logic [7:0] ofs);
      return addr_lo == ofs[7:2];
   endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// rtl/mmio_arbiter_if.sv - requester and peripheral signal bundle for the MMIO arbiter
interface mmio_arbiter_if;

   // CPU requester
   logic        c_req;
   logic        c_we;
   logic [31:0] c_addr;
   logic [15:0] c_wdata;
   logic        c_done;
   logic        c_err;
   logic [15:0] c_rdata;

   // Debug / UART loader requester
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_done;
   logic        d_err;
   logic [15:0] d_rdata;

   // Peripheral side
   logic        IORead;
   logic        IOWrite;
   logic        SwitchCtrl;
   logic        LEDCtrl;
   logic        SegCtrl;
   logic [1:0]  ioaddr;
   logic [15:0] iowdata;
   logic [15:0] switchrdata;

   // Arbiter view
   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_done, c_err, c_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_done, d_err, d_rdata,
      output IORead, IOWrite, SwitchCtrl, LEDCtrl, SegCtrl, ioaddr, iowdata,
      input  switchrdata
   );

   // Requester / peripheral environment view
   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_done, c_err, c_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_done, d_err, d_rdata,
      input  IORead, IOWrite, SwitchCtrl, LEDCtrl, SegCtrl, ioaddr, iowdata,
      output switchrdata
   );

endinterface

// File: rtl/mmio_arbiter_decode.sv
// rtl/mmio_arbiter_decode.sv - combinational MMIO address decode (addr, we -> select, err)
module mmio_decode
   import mmio_arbiter_pkg::*;
#(
   parameter logic [31:0] IO_BASE = DEF_IO_BASE,
   parameter logic [7:0]  LED_OFS = DEF_LED_OFS,
   parameter logic [7:0]  SW_OFS  = DEF_SW_OFS,
   parameter logic [7:0]  SEG_OFS = DEF_SEG_OFS
) (
   input  logic [31:2] i_addr,
   input  logic        i_we,
   output periph_sel_e o_sel,
   output logic        o_err
);

   logic w_base_hit;

   assign w_base_hit = (i_addr[31:8] == IO_BASE[31:8]);

   // Select the hit peripheral; unmapped addresses and switch writes are errors
   always_comb begin
      o_sel = SEL_NONE;
      if (w_base_hit) begin
         if (ofs_match(i_addr[7:2], LED_OFS)) begin
            o_sel = SEL_LED;
         end else if (ofs_match(i_addr[7:2], SW_OFS)) begin
            o_sel = SEL_SW;
         end else if (ofs_match(i_addr[7:2], SEG_OFS)) begin
            o_sel = SEL_SEG;
         end
      end
      o_err = (o_sel == SEL_NONE) || ((o_sel == SEL_SW) && i_we);
   end

endmodule

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - round-robin arbiter of CPU and debug requesters onto the MMIO peripherals
module mmio_arbiter
   import mmio_arbiter_pkg::*;
#(
   parameter logic [31:0] IO_BASE = DEF_IO_BASE,
   parameter logic [7:0]  LED_OFS = DEF_LED_OFS,
   parameter logic [7:0]  SW_OFS  = DEF_SW_OFS,
   parameter logic [7:0]  SEG_OFS = DEF_SEG_OFS
) (
   input  logic          clk,
   input  logic          rst,
   mmio_arbiter_if.slave bus
);

   logic [1:0]  r_state;
   logic        r_last_dbg;    // last grant, also the owner of the transaction in flight
   logic        r_we;
   logic [31:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_c_rdata;
   logic [15:0] r_d_rdata;

   logic        w_req_any;
   logic        w_grant_dbg;
   logic        w_access;
   logic        w_resp;
   logic        w_err;
   logic        w_hit;
   logic [15:0] w_rd_val;
   periph_sel_e w_sel;

   // Decode runs on the latched request so strobes depend on registers only
   mmio_decode #(
      .IO_BASE (IO_BASE),
      .LED_OFS (LED_OFS),
      .SW_OFS  (SW_OFS),
      .SEG_OFS (SEG_OFS)
   ) u_decode (
      .i_addr (r_addr[31:2]),
      .i_we   (r_we),
      .o_sel  (w_sel),
      .o_err  (w_err)
   );

   assign w_req_any   = bus.c_req | bus.d_req;
   // Debug wins when it is alone, or on a tie when the CPU had the previous grant
   assign w_grant_dbg = bus.d_req & (~bus.c_req | ~r_last_dbg);
   assign w_access    = (r_state == ST_ACCESS);
   assign w_resp      = (r_state == ST_RESP);
   assign w_hit       = w_access & ~w_err;
   // LED/SEG reads and unmapped reads return zero
   assign w_rd_val    = (w_sel == SEL_SW) ? bus.switchrdata : 16'h0000;

   // Transaction FSM: latch the winner in IDLE, one strobe cycle, one response cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_last_dbg <= 1'b1;
         r_we       <= 1'b0;
         r_addr     <= 32'h0000_0000;
         r_wdata    <= 16'h0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_any) begin
                  r_last_dbg <= w_grant_dbg;
                  r_we       <= w_grant_dbg ? bus.d_we    : bus.c_we;
                  r_addr     <= w_grant_dbg ? bus.d_addr  : bus.c_addr;
                  r_wdata    <= w_grant_dbg ? bus.d_wdata : bus.c_wdata;
                  r_state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: r_state <= ST_RESP;
            ST_RESP:   r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // Capture read data as ACCESS ends (switch data settles on the mid-cycle negedge) so it is valid with done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c_rdata <= 16'h0000;
         r_d_rdata <= 16'h0000;
      end else if (w_access && !r_we) begin
         if (r_last_dbg) begin
            r_d_rdata <= w_rd_val;
         end else begin
            r_c_rdata <= w_rd_val;
         end
      end
   end

   assign bus.IORead     = w_hit & ~r_we;
   assign bus.IOWrite    = w_hit &  r_we;
   assign bus.SwitchCtrl = w_hit & (w_sel == SEL_SW);
   assign bus.LEDCtrl    = w_hit & (w_sel == SEL_LED);
   assign bus.SegCtrl    = w_hit & (w_sel == SEL_SEG);
   assign bus.ioaddr     = r_addr[1:0];
   assign bus.iowdata    = r_wdata;

   assign bus.c_done  = w_resp & ~r_last_dbg;
   assign bus.c_err   = w_resp & ~r_last_dbg & w_err;
   assign bus.c_rdata = r_c_rdata;
   assign bus.d_done  = w_resp &  r_last_dbg;
   assign bus.d_err   = w_resp &  r_last_dbg & w_err;
   assign bus.d_rdata = r_d_rdata;

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'hFFFF_FC00, meaning the MMIO region base (upper 24 bits compared).
REQ-002 SHALL have parameter LED_OFS, default 8'h60, meaning the LED register offset.
REQ-003 SHALL have parameter SW_OFS, default 8'h70, meaning the switch register offset.
REQ-004 SHALL have parameter SEG_OFS, default 8'h80, meaning the 7-segment register offset.
REQ-005 SHALL have port clk, input, 1, system clock (rising edge).
REQ-006 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have ports c_req / c_we, input, 1 each, CPU request and write-enable.
REQ-008 SHALL have ports c_addr (32) and c_wdata (16), input, CPU address and write data.
REQ-009 SHALL have ports c_done / c_err, output, 1 each, CPU completion and error pulses.
REQ-010 SHALL have port c_rdata, output, 16, CPU read data.
REQ-011 SHALL have ports d_req, d_we, d_addr, d_wdata, d_done, d_err and d_rdata, identical to the c_* ports, for the debug/UART loader.
REQ-012 SHALL have ports IORead, IOWrite, SwitchCtrl, LEDCtrl and SegCtrl, output, 1 each, peripheral strobes.
REQ-013 SHALL have ports ioaddr (output, 2) and iowdata (output, 16), the peripheral sub-address and write data.
REQ-014 SHALL have port switchrdata, input, 16, the switch peripheral read data (captured by that peripheral on negedge clk).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; only one transaction SHALL be in flight at a time.
REQ-016 In IDLE with any req high, SHALL latch the winner's we/addr/wdata, record the winner, and go to ACCESS; with no req, SHALL stay in IDLE.
REQ-017 When both req are high in IDLE, SHALL grant the requester not granted last (round-robin); a single requester SHALL win immediately.
REQ-018 Decode SHALL hit only when addr[31:8]==IO_BASE[31:8] and addr[7:2] matches an offset's [7:2]; ioaddr SHALL be addr[1:0].
REQ-019 In ACCESS, for exactly one cycle, SHALL assert the hit peripheral's Ctrl, plus IORead (we=0) or IOWrite (we=1), with iowdata=latched wdata; then go to RESP.
REQ-020 A write to the switch address SHALL be an error: no IOWrite, err=1.
REQ-021 Reads of LED or SEG SHALL return 16'h0000 with err=0.
REQ-022 An unmapped address SHALL assert no strobe, give err=1 and rdata 0.
REQ-023 In RESP, SHALL sample switchrdata (switch read) into the winner's rdata register, pulse that requester's done (and err if set) for one cycle, and go to IDLE.
REQ-024 The loser's done/err SHALL stay 0; each rdata SHALL hold until that requester's next read completes.
REQ-025 Latency: req sampled at edge k; strobes high in cycle k..k+1; done high in cycle k+1..k+2; next grant possible at edge k+3.
REQ-026 req SHALL be ignored in ACCESS/RESP; if a requester drops req mid-transaction, the transaction SHALL still complete.
REQ-027 A req still high in IDLE after done SHALL start a new transaction.
REQ-028 All strobe outputs SHALL be 0 outside ACCESS; outputs SHALL be registered or decoded from state only (glitch-free versus requester inputs).

Reset
REQ-029 On rst, SHALL set state IDLE, all done/err/strobes 0, c_rdata=d_rdata=0, ioaddr=0, iowdata=0 and last-grant=debug, so the CPU wins the first tie.
REQ-030 rst asserted mid-transaction SHALL abort it with no done pulse; strobes SHALL drop immediately (asynchronously).

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the default offsets/base and a peripheral-select enum (NONE, LED, SW, SEG).
REQ-032 The address decode SHALL be one combinational sub-module, mmio_decode (addr, we -> select, err).

Verification
REQ-033 CPU reads 32'hFFFF_FC70 with switch=16'hA5C3: IORead+SwitchCtrl for 1 cycle, ioaddr=0, then c_done=1 with c_rdata=16'hA5C3.
REQ-034 CPU reads 32'hFFFF_FC72 with switch=16'hA5C3: c_rdata=16'h00A5.
REQ-035 Both request simultaneously after reset: CPU served first, debug next (done 3 cycles later); a second tie is granted to CPU again only after debug has been served.
REQ-036 Debug writes 16'h1234 to 32'hFFFF_FC60: IOWrite+LEDCtrl with iowdata=16'h1234 for 1 cycle; d_done=1, d_err=0.
REQ-037 CPU accesses 32'h0000_1000, and CPU writes to FC70: no strobe in either case, c_done=1 and c_err=1.
REQ-038 rst pulsed during ACCESS: strobes 0 at once, no done pulse, the next CPU request is served normally.
